mmio_io_bank: RTL and testbench
===============================

Name: mmio_io_bank

Overview:
- Parametrised memory-mapped I/O bank for the nanorv32 data-memory bus; next generation of the single in/out port at 0x1000_0000.
- Provides NPORTS channels, each with:
  - a byte-writable output register
  - a synchronised input register
  - rising-edge interrupt pending/enable registers
- Sits beside dmem. Its read data is zero when it does not acknowledge, so the system ORs it with RAM read data.

Parameters:
- BASE_ADDR, 32'h1000_0000, byte base address. Aligned to a power of two not smaller than NPORTS*16.
- NPORTS, 4, number of channels (1..16).
- WIDTH, 32, data bits per channel (1..32). Bits [31:WIDTH] read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser flops (2..4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_addr  in  32  dmem read byte address
- rd_req  in  1  read request
- rd_data  out  32  read data; valid when rd_ack=1, else 0
- rd_ack  out  1  read hit acknowledge, one cycle after rd_req
- wr_addr  in  32  dmem write byte address
- wr_data  in  32  write data
- wr_be  in  4  byte enables
- wr_req  in  1  write request
- inport  in  NPORTS*WIDTH  async inputs; channel p at [p*WIDTH +: WIDTH]
- outport  out  NPORTS*WIDTH  output registers, same packing
- irq  out  NPORTS  per-channel interrupt, registered

Behaviour:
- Register map: channel p at BASE_ADDR + p*16; addr[1:0] ignored.
  - +0x0 OUT: rw, byte-enabled.
  - +0x4 IN: ro, synchronised input.
  - +0x8 IRQ_EN: rw, byte-enabled.
  - +0xC IRQ_PEND: read returns pending bits; write-1-to-clear under wr_be.
- Hit: address in [BASE_ADDR, BASE_ADDR + NPORTS*16).
  - Misses: no ack, no state change, rd_data=0.
  - Writes to IN are ignored.
- Reset (reset=1 at clk edge): outport, IRQ_EN, IRQ_PEND, synchroniser and edge-history flops, rd_data, rd_ack and irq all clear to 0.
  - Reset mid-transaction: a read requested in the reset cycle is dropped (no ack).
- Read latency is one cycle: rd_req hit in cycle N gives rd_ack=1 and rd_data in cycle N+1, for one cycle only.
  - Back-to-back reads are allowed every cycle.
- Writes take effect at the clk edge of the wr_req cycle. A read of the same register in the next cycle returns the new value.
- Same-cycle read and write to the same register: the read returns the pre-write value.
- Inputs: SYNC_STAGES-flop synchroniser per bit, then a one-flop history.
  - Rise = sync & ~hist.
  - IN reads the synchronised value, so pin-to-IN visibility is SYNC_STAGES cycles.
- Pending: PEND |= rise every cycle, regardless of IRQ_EN.
  - A W1C and a rise on the same bit in the same cycle: set wins, bit stays 1.
- irq[p] = registered OR of (PEND_p & IRQ_EN_p). It updates the cycle after the PEND or EN change.
- The first cycle after reset never produces an edge, because hist resets to 0 and sync resets to 0.

Optional Feature:
- Macro: MMIO_IO_BANK_BOTH_EDGE_EN.
- Defined: edge = sync ^ hist, so both rising and falling input edges set PEND.
- Undefined: rising edges only.
- The register map is the same either way.

Decomposition:
- Package mmio_io_bank_pkg:
  - offset constants OFS_OUT=4'h0, OFS_IN=4'h4, OFS_IRQ_EN=4'h8, OFS_IRQ_PEND=4'hC
  - CHAN_STRIDE=16
  - the byte-enable merge function
- Sub-module io_sync_edge: one channel's WIDTH-bit synchroniser, history flop and edge output. It takes the SYNC_STAGES parameter and the MMIO_IO_BANK_BOTH_EDGE_EN define, and is instanced NPORTS times in a generate loop.

Test Plan:
1. Reset, then read 0x1000_0000 -> rd_ack=1 one cycle later, rd_data=0. outport=0 and irq=0 throughout.
2. Write 0xDEADBEEF with be=4'b0101 to channel 1 OUT (0x1000_0010), then read it back -> outport[63:32]=0x00AD00EF, and the readback equals 0x00AD00EF.
3. Drive inport channel 2 bit 3 from 0 to 1 with IRQ_EN2=0x8.
   - IN (0x1000_0024) reads 0x8 after SYNC_STAGES cycles.
   - PEND2=0x8, and irq[2] rises one cycle later.
   - W1C 0x8 to 0x1000_002C -> irq[2] falls the next cycle.
4. Issue a W1C to PEND0 bit 0 in the same cycle that bit's rising edge is detected -> PEND0 bit 0 stays 1.
5. Out-of-range read at 0x1000_0040 (NPORTS=4) and at 0x2000_0000 -> rd_ack=0, rd_data=0, no state change.
6. Assert reset during a read request with PEND nonzero -> no ack next cycle, PEND=0, irq=0.
   - With MMIO_IO_BANK_BOTH_EDGE_EN: a 1->0 input transition sets PEND.
   - Without it: a 1->0 input transition does not set PEND.

Source files
------------

// File: rtl/mmio_io_bank_pkg.sv
// Shared register-map constants and byte-enable helper for the MMIO I/O bank.
package mmio_io_bank_pkg;
  localparam logic [3:0] OFS_OUT      = 4'h0;
  localparam logic [3:0] OFS_IN       = 4'h4;
  localparam logic [3:0] OFS_IRQ_EN   = 4'h8;
  localparam logic [3:0] OFS_IRQ_PEND = 4'hC;
  localparam int         CHAN_STRIDE  = 16;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/io_sync_edge.sv
// One channel's input synchroniser, history flop and edge detect.
// MMIO_IO_BANK_BOTH_EDGE_EN selects both-edge detection; default is rising only.
module io_sync_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_det
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sq;
  logic [WIDTH-1:0]                  hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sq   <= '0;
      hist <= '0;
    end else begin
      sq   <= {sq[SYNC_STAGES-2:0], din};
      hist <= sq[SYNC_STAGES-1];
    end
  end

  assign sync = sq[SYNC_STAGES-1];
`ifdef MMIO_IO_BANK_BOTH_EDGE_EN
  assign edge_det = sync ^ hist;
`else
  assign edge_det = sync & ~hist;
`endif
endmodule

// File: rtl/mmio_io_bank.sv
// NPORTS-channel memory-mapped I/O bank on the dmem bus: OUT/IN/IRQ_EN/IRQ_PEND per channel.
// Optional both-edge interrupts via MMIO_IO_BANK_BOTH_EDGE_EN (see io_sync_edge).
module mmio_io_bank
  import mmio_io_bank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          NPORTS      = 4,
  parameter int          WIDTH       = 32,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             rd_addr,
  input  logic                    rd_req,
  output logic [31:0]             rd_data,
  output logic                    rd_ack,
  input  logic [31:0]             wr_addr,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              wr_be,
  input  logic                    wr_req,
  input  logic [NPORTS*WIDTH-1:0] inport,
  output logic [NPORTS*WIDTH-1:0] outport,
  output logic [NPORTS-1:0]       irq
);
  localparam logic [31:0] SPAN = 32'(NPORTS*CHAN_STRIDE);

  logic [NPORTS-1:0][WIDTH-1:0] out_q, en_q, pend_q, out_nx, en_nx, pend_nx, in_sync, in_edge;
  logic [31:0] rd_off, wr_off, rd_val, m_out, m_en, m_clr;
  logic [3:0]  rd_ch, wr_ch, rd_reg, wr_reg;
  logic        rd_hit, wr_hit;
  logic        unused_addr;

  for (genvar p = 0; p < NPORTS; p++) begin : g_ch
    io_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .reset    (reset),
      .din      (inport[p*WIDTH +: WIDTH]),
      .sync     (in_sync[p]),
      .edge_det (in_edge[p])
    );
  end

  // Wrapping subtraction makes addresses below BASE_ADDR land far out of range.
  assign rd_off      = rd_addr - BASE_ADDR;
  assign wr_off      = wr_addr - BASE_ADDR;
  assign rd_hit      = rd_req && (rd_off < SPAN);
  assign wr_hit      = wr_req && (wr_off < SPAN);
  assign rd_ch       = rd_off[7:4];
  assign wr_ch       = wr_off[7:4];
  assign rd_reg      = {rd_off[3:2], 2'b00};
  assign wr_reg      = {wr_off[3:2], 2'b00};
  assign unused_addr = ^{rd_off[1:0], wr_off[1:0]};
  assign outport     = out_q;

  always_comb begin
    out_nx  = out_q;
    en_nx   = en_q;
    pend_nx = pend_q;
    rd_val  = '0;
    m_out   = '0;
    m_en    = '0;
    m_clr   = '0;
    for (int p = 0; p < NPORTS; p++) begin
      m_out      = be_merge(32'(out_q[p]), wr_data, wr_be);
      m_en       = be_merge(32'(en_q[p]), wr_data, wr_be);
      m_clr      = be_merge(32'h0, wr_data, wr_be);
      pend_nx[p] = pend_q[p] | in_edge[p];
      if (wr_hit && wr_ch == 4'(p)) begin
        case (wr_reg)
          OFS_OUT:      out_nx[p]  = m_out[WIDTH-1:0];
          OFS_IRQ_EN:   en_nx[p]   = m_en[WIDTH-1:0];
          // Set from a new edge wins over a simultaneous clear.
          OFS_IRQ_PEND: pend_nx[p] = (pend_q[p] & ~m_clr[WIDTH-1:0]) | in_edge[p];
          default: ;
        endcase
      end
      if (rd_ch == 4'(p)) begin
        case (rd_reg)
          OFS_OUT:      rd_val = 32'(out_q[p]);
          OFS_IN:       rd_val = 32'(in_sync[p]);
          OFS_IRQ_EN:   rd_val = 32'(en_q[p]);
          OFS_IRQ_PEND: rd_val = 32'(pend_q[p]);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      irq     <= '0;
      rd_ack  <= 1'b0;
      rd_data <= '0;
    end else begin
      out_q   <= out_nx;
      en_q    <= en_nx;
      pend_q  <= pend_nx;
      rd_ack  <= rd_hit;
      rd_data <= rd_hit ? rd_val : '0;
      for (int p = 0; p < NPORTS; p++) irq[p] <= |(pend_q[p] & en_q[p]);
    end
  end
endmodule

// File: tb/tb_mmio_io_bank.sv
// Scoreboard bench for mmio_io_bank with default parameters.
module tb_mmio_io_bank;
  localparam int          NP   = 4;
  localparam int          W    = 32;
  localparam int          SS   = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic               clk = 1'b0;
  logic               reset;
  logic [31:0]        rd_addr, rd_data, wr_addr, wr_data;
  logic               rd_req, rd_ack, wr_req;
  logic [3:0]         wr_be;
  logic [NP*W-1:0]    inport, outport;
  logic [NP-1:0]      irq;

  typedef struct {
    int          cyc;
    logic        ack;
    logic [31:0] data;
    string       tag;
  } rd_exp_t;

  rd_exp_t q[$];
  rd_exp_t mon_e;
  int checks = 0, failures = 0, cyc = 0;

  mmio_io_bank #(.BASE_ADDR(BASE), .NPORTS(NP), .WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_req(wr_req),
    .inport(inport), .outport(outport), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Each read's expected response is due one cycle after it was issued.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc + 1 == cyc) begin
      mon_e = q.pop_front();
      chk({mon_e.tag, "_ack"}, 32'(rd_ack), 32'(mon_e.ack));
      chk({mon_e.tag, "_data"}, rd_data, mon_e.data);
    end else if (rd_ack === 1'b1) begin
      chk("spurious_ack", 32'(rd_ack), 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic ack, input logic [31:0] data, input string tag);
    rd_exp_t e;
    e.cyc = cyc; e.ack = ack; e.data = data; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic rd(input logic [31:0] a, input logic ack, input logic [31:0] d, input string tag);
    rd_addr = a; rd_req = 1'b1;
    push_rd(ack, d, tag);
    tick;
    rd_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_addr = a; wr_data = d; wr_be = be; wr_req = 1'b1;
    tick;
    wr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; inport = '0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    tick; tick;
    reset = 1'b0;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_ack", 32'(rd_ack), 32'h0);
    for (int p = 0; p < NP; p++) chk($sformatf("rst_out%0d", p), outport[p*W +: W], 32'h0);

    // 1: basic read
    rd(BASE, 1'b1, 32'h0, "t1_rd");
    chk("t1_irq", 32'(irq), 32'h0);

    // 2: byte-enabled write, readback, read-during-write
    wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'b0101);
    chk("t2_out1", outport[63:32], 32'h00AD_00EF);
    chk("t2_out0", outport[31:0], 32'h0);
    rd(BASE + 32'h10, 1'b1, 32'h00AD_00EF, "t2_rd");
    rd_addr = BASE + 32'h10; wr_addr = BASE + 32'h10;
    wr_data = 32'hFFFF_FFFF; wr_be = 4'hF; wr_req = 1'b1; rd_req = 1'b1;
    push_rd(1'b1, 32'h00AD_00EF, "t2_rdw_old");
    tick;
    wr_req = 1'b0; rd_req = 1'b0;
    rd(BASE + 32'h10, 1'b1, 32'hFFFF_FFFF, "t2_rd_new");

    // 3: input sync latency, pending, irq, W1C
    wr(BASE + 32'h28, 32'h8, 4'hF);
    inport[2*W + 3] = 1'b1;
    for (int i = 0; i <= SS; i++)
      rd(BASE + 32'h24, 1'b1, (i == SS) ? 32'h8 : 32'h0, $sformatf("t3_in%0d", i));
    chk("t3_irq_pre", 32'(irq[2]), 32'h0);
    rd(BASE + 32'h2C, 1'b1, 32'h8, "t3_pend");
    chk("t3_irq_rise", 32'(irq[2]), 32'h1);
    wr(BASE + 32'h2C, 32'h8, 4'hF);
    chk("t3_irq_hold", 32'(irq[2]), 32'h1);
    tick;
    chk("t3_irq_fall", 32'(irq[2]), 32'h0);
    rd(BASE + 32'h2C, 1'b1, 32'h0, "t3_pend_clr");
    wr(BASE + 32'h24, 32'h0, 4'hF);
    rd(BASE + 32'h24, 1'b1, 32'h8, "t3_in_ro");

    // 4: W1C in the same cycle as the detected rise
    inport[0] = 1'b1;
    tick; tick;
    wr(BASE + 32'h0C, 32'h1, 4'h1);
    rd(BASE + 32'h0C, 1'b1, 32'h1, "t4_set_wins");
    wr(BASE + 32'h0C, 32'h1, 4'h1);
    rd(BASE + 32'h0C, 1'b1, 32'h0, "t4_clr");

    // 5: misses
    rd(BASE + 32'h40, 1'b0, 32'h0, "t5_rd_hi");
    rd(32'h2000_0000, 1'b0, 32'h0, "t5_rd_far");
    rd(BASE - 32'h4, 1'b0, 32'h0, "t5_rd_lo");
    wr(BASE + 32'h40, 32'h1234_5678, 4'hF);
    wr(BASE - 32'h10, 32'h1234_5678, 4'hF);
    chk("t5_out0", outport[31:0], 32'h0);
    chk("t5_out1", outport[63:32], 32'hFFFF_FFFF);
    chk("t5_out3", outport[127:96], 32'h0);

    // 6a: falling edge behaviour
    inport[3*W] = 1'b1;
    repeat (4) tick;
    wr(BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF);
    rd(BASE + 32'h3C, 1'b1, 32'h0, "t6_pend3_clr");
    inport[3*W] = 1'b0;
    repeat (4) tick;
`ifdef MMIO_IO_BANK_BOTH_EDGE_EN
    rd(BASE + 32'h3C, 1'b1, 32'h1, "t6_fall");
`else
    rd(BASE + 32'h3C, 1'b1, 32'h0, "t6_fall");
`endif

    // 6b: reset during a read with pending set
    wr(BASE + 32'h18, 32'h20, 4'hF);
    inport[W + 5] = 1'b1;
    repeat (4) tick;
    chk("t6_irq1_pre", 32'(irq[1]), 32'h1);
    rd(BASE + 32'h1C, 1'b1, 32'h20, "t6_pend1_pre");
    inport = '0;
    repeat (4) tick;
    rd_addr = BASE + 32'h1C; rd_req = 1'b1; reset = 1'b1;
    push_rd(1'b0, 32'h0, "t6_rst_rd");
    tick;
    reset = 1'b0; rd_req = 1'b0;
    chk("t6_irq", 32'(irq), 32'h0);
    chk("t6_out1", outport[63:32], 32'h0);
    rd(BASE + 32'h1C, 1'b1, 32'h0, "t6_pend1");
    rd(BASE + 32'h18, 1'b1, 32'h0, "t6_en1");
    rd(BASE + 32'h24, 1'b1, 32'h0, "t6_in2");

    repeat (3) tick;
    chk("sb_drain", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
